// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Round-robin arbiter that shares the register file's single write port among
// NUM_REQ writeback sources. The winning write is registered onto wb_*_o, so
// the latency is one cycle. A 32-entry busy scoreboard tracks destinations
// that have been issued but not yet written back, and flags read hazards.
//
// Ports:
//   clock_i, reset_i     clock; synchronous active-high reset
//   req_valid_i          per-source write request
//   req_addr_i           per-source destination (source i at [i*ADDR_W +: ADDR_W])
//   req_data_i           per-source data (source i at [i*DATA_W +: DATA_W])
//   req_ready_o          one-hot grant (transfer = valid & ready)
//   wb_en_o/addr_o/data_o registered register-file write port
//   mark_en_i/mark_addr_i reserve a destination in the scoreboard
//   rs_addr_i/rt_addr_i  read-port query addresses
//   hazard_o             combinational: a queried register is busy
//   busy_vec_o           scoreboard contents
//
// Optional feature (macro WB_FORWARD_EN): adds fwd_rs_hit_o, fwd_rt_hit_o and
// fwd_data_o. A busy register whose write is currently on wb_* is then not
// reported as a hazard, because readers can take the value from fwd_data_o.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       wb_en_o,
  output logic [ADDR_W-1:0]          wb_addr_o,
  output logic [DATA_W-1:0]          wb_data_o,
  input  logic                       mark_en_i,
  input  logic [ADDR_W-1:0]          mark_addr_i,
  input  logic [ADDR_W-1:0]          rs_addr_i,
  input  logic [ADDR_W-1:0]          rt_addr_i,
  output logic                       hazard_o,
  output logic [31:0]                busy_vec_o
`ifdef WB_FORWARD_EN
  ,
  output logic                       fwd_rs_hit_o,
  output logic                       fwd_rt_hit_o,
  output logic [DATA_W-1:0]          fwd_data_o
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [31:0]       busy_q, busy_d;

  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Unpack the flat request buses into per-source arrays.
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  // Rotating priority search starting at rr_ptr_q. Grants are suppressed
  // during reset so a request pending at reset is never consumed.
  always_comb begin
    int idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid_i[idx] && !reset_i) begin
        grant_any      = 1'b1;
        grant_idx      = idx[PTR_W-1:0];
        grant[idx]     = 1'b1;
      end
    end
  end

  assign sel_addr = addr_arr[grant_idx];
  assign sel_data = data_arr[grant_idx];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    busy_d    = busy_q;
    if (grant_any) begin
      rr_ptr_d  = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
      // Writes to register 0 are acknowledged but never reach the file.
      wb_en_d   = (sel_addr != '0);
      wb_addr_d = sel_addr;
      wb_data_d = sel_data;
      if (sel_addr != '0) busy_d[sel_addr] = 1'b0;
    end
    // Applied after the clear: a newly issued producer owns the register.
    if (mark_en_i && mark_addr_i != '0) busy_d[mark_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rr_ptr_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  logic rs_busy, rt_busy;

`ifdef WB_FORWARD_EN
  logic rs_fwd, rt_fwd;
  assign rs_fwd       = wb_en_q && (wb_addr_q == rs_addr_i) && (rs_addr_i != '0);
  assign rt_fwd       = wb_en_q && (wb_addr_q == rt_addr_i) && (rt_addr_i != '0);
  assign fwd_rs_hit_o = rs_fwd;
  assign fwd_rt_hit_o = rt_fwd;
  assign fwd_data_o   = wb_data_q;
  assign rs_busy      = (rs_addr_i != '0) && busy_q[rs_addr_i] && !rs_fwd;
  assign rt_busy      = (rt_addr_i != '0) && busy_q[rt_addr_i] && !rt_fwd;
`else
  assign rs_busy      = (rs_addr_i != '0) && busy_q[rs_addr_i];
  assign rt_busy      = (rt_addr_i != '0) && busy_q[rt_addr_i];
`endif

  assign hazard_o    = rs_busy || rt_busy;
  assign req_ready_o = grant;
  assign wb_en_o     = wb_en_q;
  assign wb_addr_o   = wb_addr_q;
  assign wb_data_o   = wb_data_q;
  assign busy_vec_o  = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with a reference model and a
// queue of expected writeback results.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clock, reset;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              mark_en;
  logic [AW-1:0]     mark_addr, rs_addr, rt_addr;
  logic              hazard;
  logic [31:0]       busy_vec;
`ifdef WB_FORWARD_EN
  logic              fwd_rs_hit, fwd_rt_hit;
  logic [DW-1:0]     fwd_data;
`endif

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_i(clock), .reset_i(reset),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready),
    .wb_en_o(wb_en), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
    .mark_en_i(mark_en), .mark_addr_i(mark_addr),
    .rs_addr_i(rs_addr), .rt_addr_i(rt_addr),
    .hazard_o(hazard), .busy_vec_o(busy_vec)
`ifdef WB_FORWARD_EN
    , .fwd_rs_hit_o(fwd_rs_hit), .fwd_rt_hit_o(fwd_rt_hit), .fwd_data_o(fwd_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   busy;
  } wb_t;
  wb_t exp_q[$];

  // Reference model state
  int            m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [31:0]   m_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // One cycle: drive, check the combinational grant, predict the registered
  // result, then compare it after the clock edge.
  task automatic drive_cycle(input string tag, input logic [N-1:0] v,
                             input logic mk, input logic [AW-1:0] ma);
    int g;
    int idx;
    logic [N-1:0] exp_ready;
    wb_t e, o;
    req_valid = v;
    mark_en   = mk;
    mark_addr = ma;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    check({tag, ".onehot"}, 64'($onehot0(req_ready)), 64'(1));
    e.en = 1'b0;
    if (g >= 0) begin
      m_addr = req_addr[g*AW +: AW];
      m_data = req_data[g*DW +: DW];
      m_ptr  = (g + 1) % N;
      e.en   = (m_addr != '0);
      if (m_addr != '0) m_busy[m_addr] = 1'b0;
    end
    if (mk && ma != '0) m_busy[ma] = 1'b1;
    e.addr = m_addr;
    e.data = m_data;
    e.busy = m_busy;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    o = exp_q.pop_front();
    check({tag, ".wb_en"},   64'(wb_en),    64'(o.en));
    check({tag, ".wb_addr"}, 64'(wb_addr),  64'(o.addr));
    check({tag, ".wb_data"}, 64'(wb_data),  64'(o.data));
    check({tag, ".busy"},    64'(busy_vec), 64'(o.busy));
    $display("txn %s valid=%b ready=%b wb_en=%0b wb_addr=%0d wb_data=0x%0h busy=0x%0h",
             tag, v, exp_ready, wb_en, wb_addr, wb_data, busy_vec);
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    mark_en = 1'b0; mark_addr = '0; rs_addr = '0; rt_addr = '0;
    m_ptr = 0; m_addr = '0; m_data = '0; m_busy = '0;

    // Reset with every source requesting
    set_src(0, 5'd5, 32'hA000_0005);
    set_src(1, 5'd6, 32'hA000_0006);
    set_src(2, 5'd7, 32'hA000_0007);
    req_valid = 3'b111;
    @(posedge clock); @(posedge clock); #1;
    check("rst.ready",   64'(req_ready), 64'(0));
    check("rst.wb_en",   64'(wb_en),     64'(0));
    check("rst.wb_addr", 64'(wb_addr),   64'(0));
    check("rst.wb_data", 64'(wb_data),   64'(0));
    check("rst.busy",    64'(busy_vec),  64'(0));
    reset = 1'b0;

    // Continuous contention: grants rotate 0,1,2,0,1,2
    for (int i = 0; i < 6; i++) drive_cycle($sformatf("rr%0d", i), 3'b111, 1'b0, '0);

    // Lone source 2 with the pointer at 0
    set_src(2, 5'd31, 32'hDEAD_BEEF);
    drive_cycle("lone2", 3'b100, 1'b0, '0);
    set_src(2, 5'd7, 32'hA000_0007);
    drive_cycle("after_lone", 3'b111, 1'b0, '0);

    // Mark register 8, observe hazard, then clear it with a write
    drive_cycle("mark8", 3'b000, 1'b1, 5'd8);
    rs_addr = 5'd8; #1;
    check("haz8.set", 64'(hazard), 64'(1));
    set_src(1, 5'd8, 32'h0000_0088);
    drive_cycle("write8", 3'b010, 1'b0, '0);
    check("haz8.clr", 64'(hazard), 64'(0));

    // Mark and write register 9 in the same cycle: mark wins
    set_src(0, 5'd9, 32'h0000_0099);
    drive_cycle("mark_wr9", 3'b001, 1'b1, 5'd9);
    check("busy9", 64'(busy_vec[9]), 64'(1));

    // Write to register 0: acknowledged, no write, busy unchanged
    set_src(2, 5'd0, 32'h0000_1234);
    drive_cycle("write0", 3'b100, 1'b0, '0);
    check("write0.en", 64'(wb_en), 64'(0));
    rt_addr = 5'd9; #1;
    check("haz9", 64'(hazard), 64'(1));

    // Marking register 0 is ignored
    drive_cycle("mark0", 3'b000, 1'b1, 5'd0);

    // Register 4 busy while its write sits on wb_*
    rs_addr = '0;
    set_src(1, 5'd4, 32'h4444_0004);
    drive_cycle("mark_wr4", 3'b010, 1'b1, 5'd4);
    rt_addr = 5'd4; #1;
`ifdef WB_FORWARD_EN
    check("fwd.rt_hit", 64'(fwd_rt_hit), 64'(1));
    check("fwd.rs_hit", 64'(fwd_rs_hit), 64'(0));
    check("fwd.data",   64'(fwd_data),   64'(32'h4444_0004));
    check("fwd.hazard", 64'(hazard),     64'(0));
`else
    check("nofwd.hazard", 64'(hazard), 64'(1));
`endif

    drive_cycle("idle", 3'b000, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
